pipe_hazard_ctl: RTL and testbench

- Central sequencing controller for the SIMPLE 5-phase pipeline (P1 fetch, P2 decode, P3 execute, P4 memory, P5 writeback).
- Drives PC write-enable, P1/P2 register enable, P2/P3 bubble insertion and P1/P2 flush.
- Handles load-use stalls, taken-branch squash and HLT drain.
- Sits beside the phase control registers. Their enables and clears come from this block.

---
 rtl/pipe_hazard_ctl_pkg.sv | 11 +
 rtl/pipe_hazard_ctl_hazard_detect.sv | 16 +
 rtl/pipe_hazard_ctl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctl_pkg.sv
// pipe_ctl_pkg: shared state encoding and constants for the pipeline sequencing controller.
package pipe_ctl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } state_e;
  localparam int REG_W_DEF = 3;
  localparam logic [5:0] NOP_OP = 6'h00;
endpackage

// File: rtl/pipe_hazard_ctl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the P2 sources and the P3 load target.
module hazard_detect
  import pipe_ctl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             use_rs_i,
  input  logic             use_rt_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             memread_i,
  output logic             hazard_o
);
  assign hazard_o = memread_i & ((use_rs_i & (rs_i == rd_i)) | (use_rt_i & (rt_i == rd_i)));
endmodule

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: sequences PC/P1-P2 enables, flushes and bubbles for load-use stalls, branch squash and HLT drain.
module pipe_hazard_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_hlt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q;
  logic             hazard;
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .use_rs_i  (id_use_rs),
    .use_rt_i  (id_use_rt),
    .rd_i      (ex_rd),
    .memread_i (ex_memread),
    .hazard_o  (hazard)
  );
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    cnt_d        = cnt_q;
    pc_we        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Branch squashes P1/P2 outright, so a hazard or HLT sitting there is moot.
        if (br_taken) begin
          pc_we        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hazard) begin
          id_ex_bubble = 1'b1;
          cnt_d        = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end else if (id_hlt) begin
          dcnt_d  = DW'(DRAIN_CYC - 1);
          state_d = DRAIN;
        end else begin
          pc_we    = 1'b1;
          if_id_en = 1'b1;
        end
      end
      DRAIN: begin
        if (br_taken) begin
          pc_we        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          dcnt_d       = '0;
          state_d      = RUN;
        end else begin
          id_ex_bubble = 1'b1;
          state_d      = dcnt_q == '0 ? HALTED : DRAIN;
          dcnt_d       = dcnt_q == '0 ? dcnt_q : dcnt_q - 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == IDLE) || (state_d == HALTED);
    end
  end
  assign halted    = halted_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: directed scenario tests for the pipeline sequencing controller.
module tb_pipe_hazard_ctl;
  logic        clk = 1'b0;
  logic        rst_n, start, id_use_rs, id_use_rt, id_hlt, ex_memread, br_taken;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        pc_we, if_id_en, if_id_flush, id_ex_bubble, halted;
  logic [15:0] stall_cnt;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctl #(.REG_W(3), .DRAIN_CYC(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_hlt       (id_hlt),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .br_taken     (br_taken),
    .pc_we        (pc_we),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    start = 0; id_use_rs = 0; id_use_rt = 0; id_hlt = 0; ex_memread = 0; br_taken = 0;
    id_rs = 0; id_rt = 0; ex_rd = 7;
    #1;
  endtask
  task automatic load_use_rs3();
    ex_memread = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    clr();
    tick(); tick();
    rst_n = 1;
    tick();
    nvec++; if ({halted, pc_we, if_id_en, if_id_flush, id_ex_bubble} !== 5'b10011) begin nerr++; $display("FAIL reset_ctl got %b want 10011", {halted, pc_we, if_id_en, if_id_flush, id_ex_bubble}); end
    nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    start = 1;
    tick();
    start = 0; #1;
    nvec++; if ({pc_we, if_id_en, halted, if_id_flush, id_ex_bubble} !== 5'b11000) begin nerr++; $display("FAIL start_run got %b want 11000", {pc_we, if_id_en, halted, if_id_flush, id_ex_bubble}); end
  endtask
  task automatic test_load_use();
    load_use_rs3();
    nvec++; if ({pc_we, if_id_en, id_ex_bubble, if_id_flush} !== 4'b0010) begin nerr++; $display("FAIL lu_ctl got %b want 0010", {pc_we, if_id_en, id_ex_bubble, if_id_flush}); end
    tick();
    clr();
    nvec++; if (stall_cnt !== 16'd1) begin nerr++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    nvec++; if (pc_we !== 1'b1) begin nerr++; $display("FAIL lu_resume got %b want 1", pc_we); end
    id_rt = 5; id_use_rt = 1; ex_rd = 5; ex_memread = 1; #1;
    nvec++; if ({pc_we, id_ex_bubble} !== 2'b01) begin nerr++; $display("FAIL lu_rt got %b want 01", {pc_we, id_ex_bubble}); end
    tick();
    clr();
    nvec++; if (stall_cnt !== 16'd2) begin nerr++; $display("FAIL lu_rt_cnt got %0d want 2", stall_cnt); end
  endtask
  task automatic test_no_false_stall();
    logic [4:0] vecs [3] = '{5'b1_0_011, 5'b1_1_100, 5'b0_1_011};
    for (int i = 0; i < 3; i++) begin
      ex_memread = vecs[i][4]; id_use_rs = vecs[i][3]; ex_rd = vecs[i][2:0]; id_rs = 3; #1;
      nvec++; if ({pc_we, if_id_en, id_ex_bubble} !== 3'b110) begin nerr++; $display("FAIL nostall_%0d got %b want 110", i, {pc_we, if_id_en, id_ex_bubble}); end
      tick();
      nvec++; if (stall_cnt !== 16'd2) begin nerr++; $display("FAIL nostall_cnt_%0d got %0d want 2", i, stall_cnt); end
    end
    clr();
  endtask
  task automatic test_branch_priority();
    load_use_rs3();
    id_hlt = 1; br_taken = 1; #1;
    nvec++; if ({pc_we, if_id_en, if_id_flush, id_ex_bubble} !== 4'b1111) begin nerr++; $display("FAIL br_prio got %b want 1111", {pc_we, if_id_en, if_id_flush, id_ex_bubble}); end
    tick();
    clr();
    nvec++; if ({stall_cnt, pc_we, halted} !== {16'd2, 2'b10}) begin nerr++; $display("FAIL br_after cnt=%0d pc_we=%b halted=%b want cnt=2 pc_we=1 halted=0", stall_cnt, pc_we, halted); end
  endtask
  task automatic test_hlt_drain();
    id_hlt = 1; #1;
    nvec++; if ({pc_we, if_id_en, if_id_flush, id_ex_bubble} !== 4'b0000) begin nerr++; $display("FAIL hlt_pass got %b want 0000", {pc_we, if_id_en, if_id_flush, id_ex_bubble}); end
    tick();
    clr();
    for (int i = 0; i < 3; i++) begin
      nvec++; if ({pc_we, if_id_en, id_ex_bubble, halted} !== 4'b0010) begin nerr++; $display("FAIL drain_%0d got %b want 0010", i, {pc_we, if_id_en, id_ex_bubble, halted}); end
      tick();
    end
    nvec++; if ({halted, if_id_flush, pc_we} !== 3'b110) begin nerr++; $display("FAIL halted got %b want 110", {halted, if_id_flush, pc_we}); end
    start = 1;
    tick();
    start = 0; #1;
    nvec++; if ({pc_we, halted, stall_cnt} !== {2'b10, 16'd0}) begin nerr++; $display("FAIL resume pc_we=%b halted=%b cnt=%0d want 1 0 0", pc_we, halted, stall_cnt); end
  endtask
  task automatic test_branch_in_drain();
    id_hlt = 1; #1;
    tick();
    clr();
    tick();
    br_taken = 1; #1;
    nvec++; if ({pc_we, if_id_flush, id_ex_bubble} !== 3'b111) begin nerr++; $display("FAIL drain_br got %b want 111", {pc_we, if_id_flush, id_ex_bubble}); end
    tick();
    clr();
    for (int i = 0; i < 4; i++) begin
      nvec++; if ({pc_we, if_id_en, halted} !== 3'b110) begin nerr++; $display("FAIL drain_br_run_%0d got %b want 110", i, {pc_we, if_id_en, halted}); end
      tick();
    end
  endtask
  task automatic test_reset_mid_drain();
    load_use_rs3();
    tick();
    clr();
    nvec++; if (stall_cnt !== 16'd1) begin nerr++; $display("FAIL pre_rst_cnt got %0d want 1", stall_cnt); end
    id_hlt = 1; #1;
    tick();
    clr();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; #1;
    nvec++; if ({halted, pc_we, if_id_flush, stall_cnt} !== {3'b101, 16'd0}) begin nerr++; $display("FAIL rst_drain halted=%b pc_we=%b flush=%b cnt=%0d want 1 0 1 0", halted, pc_we, if_id_flush, stall_cnt); end
    tick(); tick(); tick();
    nvec++; if ({halted, pc_we} !== 2'b10) begin nerr++; $display("FAIL rst_stay_idle got %b want 10", {halted, pc_we}); end
  endtask
  task automatic test_saturation();
    start = 1;
    tick();
    start = 0;
    load_use_rs3();
    repeat (65535) tick();
    nvec++; if (stall_cnt !== 16'hFFFF) begin nerr++; $display("FAIL sat_reach got %h want ffff", stall_cnt); end
    repeat (5) tick();
    nvec++; if ({stall_cnt, pc_we} !== {16'hFFFF, 1'b0}) begin nerr++; $display("FAIL sat_hold cnt=%h pc_we=%b want ffff 0", stall_cnt, pc_we); end
    clr();
    tick();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_priority();
    test_hlt_drain();
    test_branch_in_drain();
    test_reset_mid_drain();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
